// File: rtl/mul_arb_pkg.sv
// Shared defaults and FSM state type for the time-shared repeated-add multiplier.
package mul_arb_pkg;
    localparam int OPW_DEF = 16;
    localparam int PW_DEF  = 32;
    localparam int NCLIENT = 2;

    typedef enum logic [1:0] {IDLE, CALC, DONE} arb_state_t;
endpackage

// File: rtl/mul_rep_add_core.sv
// Datapath: operand/accumulator registers, adder and B decrementer.
module mul_rep_add_core
    import mul_arb_pkg::*;
#(
    parameter int OPW = OPW_DEF,
    parameter int PW  = PW_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           ldA,
    input  logic           ldB,
    input  logic           ldP,
    input  logic           clrP,
    input  logic           decB,
    input  logic [OPW-1:0] a_in,
    input  logic [OPW-1:0] b_in,
    output logic           eqz,
    output logic [PW-1:0]  p
);
    logic [OPW-1:0] a_q;
    logic [OPW-1:0] b_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= '0;
            b_q <= '0;
            p   <= '0;
        end else begin
            if (ldA) a_q <= a_in;
            if (ldB) b_q <= b_in;
            else if (decB) b_q <= b_q - OPW'(1);
            if (clrP) p <= '0;
            else if (ldP) p <= p + PW'(a_q);
        end
    end

    assign eqz = (b_q == '0);
endmodule

// File: rtl/mul_share_arbiter.sv
// Two-client round-robin arbiter sharing one repeated-add multiplier core.
module mul_share_arbiter
    import mul_arb_pkg::*;
#(
    parameter int OPW = OPW_DEF,
    parameter int PW  = PW_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req0,
    input  logic           req1,
    input  logic [OPW-1:0] a0,
    input  logic [OPW-1:0] b0,
    input  logic [OPW-1:0] a1,
    input  logic [OPW-1:0] b1,
    output logic           gnt0,
    output logic           gnt1,
    output logic           done0,
    output logic           done1,
    output logic [PW-1:0]  prod,
    output logic           busy,
    output logic           owner
);
    arb_state_t    state, nxt;
    logic          ptr;
    logic          sel;
    logic          grant;
    logic          ldA, ldB, ldP, clrP, decB;
    logic          eqz;
    logic [PW-1:0] p;

    mul_rep_add_core #(.OPW(OPW), .PW(PW)) u_core (
        .clk  (clk),
        .rst_n(rst_n),
        .ldA  (ldA),
        .ldB  (ldB),
        .ldP  (ldP),
        .clrP (clrP),
        .decB (decB),
        .a_in (sel ? a1 : a0),
        .b_in (sel ? b1 : b0),
        .eqz  (eqz),
        .p    (p)
    );

    always_comb begin
        nxt   = state;
        gnt0  = 1'b0;
        gnt1  = 1'b0;
        ldA   = 1'b0;
        ldB   = 1'b0;
        ldP   = 1'b0;
        clrP  = 1'b0;
        decB  = 1'b0;
        grant = 1'b0;
        // lone requester wins; pointer only breaks ties
        sel   = (req0 && req1) ? ptr : req1;
        case (state)
            IDLE: begin
                grant = rst_n && (req0 || req1);
                gnt0  = grant && !sel;
                gnt1  = grant && sel;
                ldA   = grant;
                ldB   = grant;
                clrP  = grant;
                if (grant) nxt = CALC;
            end
            CALC: begin
                if (eqz) begin
                    nxt = DONE;
                end else begin
                    ldP  = 1'b1;
                    decB = 1'b1;
                end
            end
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= 1'b0;
            owner <= 1'b0;
            prod  <= '0;
        end else begin
            state <= nxt;
            if (grant) begin
                owner <= sel;
                ptr   <= ~sel;
            end
            // product is final on the CALC->DONE edge, so it is visible during DONE
            if (state == CALC && eqz) prod <= p;
        end
    end

    assign done0 = (state == DONE) && !owner;
    assign done1 = (state == DONE) && owner;
    assign busy  = (state != IDLE);
endmodule

// File: tb/tb_mul_share_arbiter.sv
// Randomized and directed bench with a transaction-timing reference model.
module tb_mul_share_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [15:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic        gnt0, gnt1, done0, done1, busy, owner;
    logic [31:0] prod;

    int n_cmp = 0;
    int n_err = 0;

    mul_share_arbiter #(.OPW(16), .PW(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .prod(prod), .busy(busy), .owner(owner)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Reference model: a grant occupies the core for b+3 cycles, done lands at gnt+b+2.
    int          cyc = 0;
    int          free_at = 0;
    int          gnt_at = 0;
    int          done_at = 0;
    bit          pend = 0;
    bit          pref = 0;
    bit          exp_owner = 0;
    bit          pend_owner = 0;
    logic [31:0] exp_prod = '0;
    logic [31:0] pend_prod = '0;

    always @(negedge clk) begin
        bit eg0, eg1, win, ed0, ed1, eb;
        cyc++;
        if (!rst_n) begin
            pend = 0; pref = 0; exp_owner = 0; exp_prod = '0; free_at = 0;
            chk("rst_outs", {gnt0, gnt1, done0, done1, busy, owner}, 6'b0);
            chk("rst_prod", prod, 32'd0);
        end else begin
            eb  = pend && (cyc > gnt_at);
            ed0 = pend && (cyc == done_at) && !pend_owner;
            ed1 = pend && (cyc == done_at) && pend_owner;
            if (pend && cyc == done_at) begin
                exp_prod = pend_prod;
                pend = 0;
            end
            chk("busy", busy, eb);
            chk("done", {done0, done1}, {ed0, ed1});
            chk("prod", prod, exp_prod);
            chk("owner", owner, exp_owner);
            eg0 = 0; eg1 = 0;
            if (cyc >= free_at && (req0 || req1)) begin
                win = (req0 && req1) ? pref : req1;
                eg0 = !win;
                eg1 = win;
                pref = ~win;
                exp_owner = win;
                pend = 1;
                pend_owner = win;
                gnt_at = cyc;
                pend_prod = win ? 32'(a1) * 32'(b1) : 32'(a0) * 32'(b0);
                done_at = cyc + (win ? int'(b1) : int'(b0)) + 2;
                free_at = done_at + 1;
            end
            chk("gnt", {gnt0, gnt1}, {eg0, eg1});
        end
    end

    task automatic serve(input bit ch, input logic [15:0] a, input logic [15:0] b,
                         input int give_up);
        int n = 0;
        bit granted = 0;
        @(posedge clk); #1;
        if (!ch) begin a0 = a; b0 = b; req0 = 1'b1; end
        else     begin a1 = a; b1 = b; req1 = 1'b1; end
        while (n < 300) begin
            @(negedge clk);
            if (ch ? gnt1 : gnt0) begin granted = 1; break; end
            n++;
            if (give_up > 0 && n >= give_up) break;
        end
        if (give_up == 0) chk("gnt_seen", granted, 1'b1);
        @(posedge clk); #1;
        if (!ch) req0 = 1'b0; else req1 = 1'b0;
    endtask

    task automatic client(input bit ch, input int n);
        repeat (n) begin
            logic [15:0] a, b;
            int gu;
            repeat ($urandom_range(0, 6)) @(posedge clk);
            a  = 16'($urandom);
            b  = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(0, 40))
                                             : 16'($urandom_range(0, 12));
            gu = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 4) : 0;
            serve(ch, a, b, gu);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        // simultaneous requests straight out of reset
        fork
            serve(1'b0, 16'd3, 16'd4, 0);
            serve(1'b1, 16'd6, 16'd2, 0);
        join
        repeat (8) @(posedge clk);
        serve(1'b0, 16'd17, 16'd5, 0);
        serve(1'b1, 16'd1234, 16'd0, 0);
        serve(1'b0, 16'd65535, 16'd3, 0);
        serve(1'b0, 16'd9, 16'd20, 0);
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        serve(1'b0, 16'd2, 16'd2, 0);
        repeat (8) @(posedge clk);
        // both clients held continuously
        #1;
        a0 = 16'd1; b0 = 16'd1; a1 = 16'd1; b1 = 16'd1;
        req0 = 1'b1; req1 = 1'b1;
        repeat (24) @(posedge clk);
        #1 req0 = 1'b0; req1 = 1'b0;
        repeat (8) @(posedge clk);
        fork
            client(1'b0, 40);
            client(1'b1, 40);
        join
        repeat (60) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mul_share_arbiter.md
MUL_SHARE_ARBITER -- requirements
Module: mul_share_arbiter

Interface
REQ-001 Parameter OPW, 16: operand width (A, B).
REQ-002 Parameter PW, 32: product width, SHALL be at least 2*OPW.
REQ-003 Port clk  input  1: single clock, all state updates on its rising edge.
REQ-004 Port rst_n  input  1: reset, asynchronous, active-low.
REQ-005 Port req0 / req1  input  1 each: client request, level, held until that client's gnt.
REQ-006 Port a0, b0 / a1, b1  input  OPW each: client operands, stable while the client's req is high.
REQ-007 Port gnt0 / gnt1  output  1 each: one-cycle pulse; the client's operands are captured on this cycle's rising edge.
REQ-008 Port done0 / done1  output  1 each: one-cycle pulse; prod valid for the owning client.
REQ-009 Port prod  output  PW: shared result bus, holds the last product until the next done.
REQ-010 Port busy  output  1: high from the cycle after gnt through the done cycle.
REQ-011 Port owner  output  1: index of the client currently or last served.

Function
REQ-012 FSM states SHALL be IDLE, CALC and DONE; reset state IDLE.
REQ-013 IDLE: gnt is combinational from req and the round-robin pointer, at most one gnt high per cycle; gnt SHALL be 0 when both req are low.
REQ-014 On the gnt edge: A<=a_i, B<=b_i, P<=0, owner<=i, next state CALC.
REQ-015 CALC, B!=0: P<=P+A (zero-extended to PW), B<=B-1, stay in CALC.
REQ-016 CALC, B==0: go to DONE with no P update.
REQ-017 DONE: done_i=1 for owner, prod=P, next state IDLE; no gnt is issued in DONE.
REQ-018 Latency: for B=k, done asserts exactly k+2 cycles after the gnt cycle; next gnt earliest k+3.
REQ-019 Round-robin: pointer favours client 0 after reset; after a client is granted, the pointer favours the other client; with a single requester that client wins regardless of pointer.
REQ-020 Requests arriving while busy SHALL wait, not be lost, and be granted in the first IDLE cycle.
REQ-021 A req still high in IDLE after its own done SHALL be treated as a new request.
REQ-022 A req dropped before gnt SHALL be discarded with no side effect.
REQ-023 The product SHALL be exact mod 2^PW; no overflow for any OPW-bit operands with PW>=2*OPW.

Reset
REQ-024 rst_n low SHALL immediately force: state IDLE, gnt0/1=0, done0/1=0, busy=0, owner=0, prod=0, A=B=P=0, pointer to client 0.
REQ-025 Reset during CALC SHALL abort the operation; no done for the aborted request after release.
REQ-026 First gnt possible in the first cycle rst_n is high with req asserted.

Structure
REQ-027 Package mul_arb_pkg SHALL hold OPW/PW defaults, the client count (2) and the FSM state enum.
REQ-028 Sub-module mul_rep_add_core SHALL hold the A/B/P registers and the adder/decrementer. It has ldA, ldB, ldP, clrP, decB controls and an eqz (B==0) flag. The arbiter FSM drives its controls.
REQ-029 The arbiter SHALL contain only the FSM, the round-robin pointer and the owner/output registers.

Verification
REQ-030 req0, a0=17, b0=5 -> gnt0 at cycle t, done0 at t+7, prod=85, owner=0.
REQ-031 After reset, req0 (3x4) and req1 (6x2) together -> gnt0 first, prod=12 at done0; gnt1 next IDLE cycle, prod=12 at done1.
REQ-032 a1=1234, b1=0 -> done1 exactly 2 cycles after gnt1, prod=0.
REQ-033 a0=65535, b0=3 -> prod=196605, no truncation.
REQ-034 rst_n low for 1 cycle during CALC of 9x20 -> all outputs 0 immediately, no done; then 2x2 -> prod=4.
REQ-035 req0 and req1 held continuously, all operands 1x1 -> grants alternate 0,1,0,1; each done at gnt+3.
